// File: rtl/vga_scaled_timing.sv
// VGA raster generator with integer pixel replication, a fetch-latency-matched colour pipeline
// and delay-matched sync, blanking and frame/line markers.
module vga_scaled_timing #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33,
  parameter int unsigned SCALE         = 1,
  parameter int unsigned COLOR_BITS    = 4,
  parameter int unsigned FETCH_LATENCY = 1,
  parameter bit          HSYNC_POL     = 1'b0,
  parameter bit          VSYNC_POL     = 1'b0
) (
  input  logic                      clk_25_175,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [3*COLOR_BITS-1:0]   pixstream,
  output logic [9:0]                hreadwire,
  output logic [9:0]                vreadwire,
  output logic                      fetch_valid,
  output logic [COLOR_BITS-1:0]     r,
  output logic [COLOR_BITS-1:0]     g,
  output logic [COLOR_BITS-1:0]     b,
  output logic                      h_sync,
  output logic                      v_sync,
  output logic                      drawing_pixels,
  output logic                      line_start,
  output logic                      frame_start,
  output logic [7:0]                frame_count
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W     = $clog2(H_TOTAL + 1);
  localparam int unsigned VC_W     = $clog2(V_TOTAL + 1);
  localparam int unsigned SUB_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned PIPE     = FETCH_LATENCY + 2;
  localparam int unsigned PIX_W    = 3 * COLOR_BITS;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic              run_q, run_d;
  logic [HC_W-1:0]   hcnt_q, hcnt_d;
  logic [VC_W-1:0]   vcnt_q, vcnt_d;
  logic [SUB_W-1:0]  hsub_q, hsub_d;
  logic [SUB_W-1:0]  vsub_q, vsub_d;
  logic [9:0]        hlog_q, hlog_d;
  logic [9:0]        vlog_q, vlog_d;

  logic [9:0]        hreadwire_q, hreadwire_d;
  logic [9:0]        vreadwire_q, vreadwire_d;
  logic              fetch_valid_q, fetch_valid_d;

  logic [PIPE-1:0]   act_pipe_q, act_pipe_d;
  logic [PIPE-1:0]   hs_pipe_q, hs_pipe_d;
  logic [PIPE-1:0]   vs_pipe_q, vs_pipe_d;
  logic [PIPE-1:0]   ls_pipe_q, ls_pipe_d;
  logic [PIPE-1:0]   fs_pipe_q, fs_pipe_d;
  logic [PIX_W-1:0]  rgb_q, rgb_d;
  logic [7:0]        frame_count_q, frame_count_d;

  logic h_act0, v_act0, act0, hs0, vs0, ls0, fs0;

  // Stage-0 decode; everything is gated by run_q so a stopped raster looks blank.
  assign h_act0 = (hcnt_q < HC_W'(H_ACTIVE));
  assign v_act0 = (vcnt_q < VC_W'(V_ACTIVE));
  assign act0   = run_q & h_act0 & v_act0;
  assign hs0    = run_q & (hcnt_q >= HC_W'(HS_START)) & (hcnt_q < HC_W'(HS_END));
  assign vs0    = run_q & (vcnt_q >= VC_W'(VS_START)) & (vcnt_q < VC_W'(VS_END));
  assign ls0    = run_q & (hcnt_q == '0) & v_act0;
  assign fs0    = run_q & (hcnt_q == '0) & (vcnt_q == '0);

  // Raster and logical-coordinate counters; the first enabled clock holds (0,0).
  always_comb begin
    run_d  = enable;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    hsub_d = hsub_q;
    vsub_d = vsub_q;
    hlog_d = hlog_q;
    vlog_d = vlog_q;
    if (!enable) begin
      hcnt_d = '0;
      vcnt_d = '0;
      hsub_d = '0;
      vsub_d = '0;
      hlog_d = '0;
      vlog_d = '0;
    end else if (run_q) begin
      if (hcnt_q == HC_W'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VC_W'(V_TOTAL - 1)) ? '0 : vcnt_q + VC_W'(1);
      end else begin
        hcnt_d = hcnt_q + HC_W'(1);
      end
      if (h_act0 && v_act0) begin
        if (hsub_q == SUB_W'(SCALE - 1)) begin
          hsub_d = '0;
          hlog_d = (hcnt_q == HC_W'(H_ACTIVE - 1)) ? '0 : hlog_q + 10'd1;
        end else begin
          hsub_d = hsub_q + SUB_W'(1);
        end
      end
      if ((hcnt_q == HC_W'(H_ACTIVE - 1)) && v_act0) begin
        if (vsub_q == SUB_W'(SCALE - 1)) begin
          vsub_d = '0;
          vlog_d = (vcnt_q == VC_W'(V_ACTIVE - 1)) ? '0 : vlog_q + 10'd1;
        end else begin
          vsub_d = vsub_q + SUB_W'(1);
        end
      end
    end
  end

  // Fetch stage, delay-matched control and the colour capture stage.
  always_comb begin
    fetch_valid_d = act0;
    hreadwire_d   = act0 ? hlog_q : '0;
    vreadwire_d   = act0 ? vlog_q : '0;
    act_pipe_d    = {act_pipe_q[PIPE-2:0], act0};
    hs_pipe_d     = {hs_pipe_q[PIPE-2:0], (hs0 ? HSYNC_POL : ~HSYNC_POL)};
    vs_pipe_d     = {vs_pipe_q[PIPE-2:0], (vs0 ? VSYNC_POL : ~VSYNC_POL)};
    ls_pipe_d     = {ls_pipe_q[PIPE-2:0], ls0};
    fs_pipe_d     = {fs_pipe_q[PIPE-2:0], fs0};
    rgb_d         = pixstream & {PIX_W{act_pipe_q[PIPE-2]}};
    frame_count_d = frame_count_q + 8'(fs_pipe_q[PIPE-2]);
  end

  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      run_q         <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsub_q        <= '0;
      vsub_q        <= '0;
      hlog_q        <= '0;
      vlog_q        <= '0;
      hreadwire_q   <= '0;
      vreadwire_q   <= '0;
      fetch_valid_q <= 1'b0;
      act_pipe_q    <= '0;
      hs_pipe_q     <= {PIPE{~HSYNC_POL}};
      vs_pipe_q     <= {PIPE{~VSYNC_POL}};
      ls_pipe_q     <= '0;
      fs_pipe_q     <= '0;
      rgb_q         <= '0;
      frame_count_q <= '0;
    end else begin
      run_q         <= run_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsub_q        <= hsub_d;
      vsub_q        <= vsub_d;
      hlog_q        <= hlog_d;
      vlog_q        <= vlog_d;
      hreadwire_q   <= hreadwire_d;
      vreadwire_q   <= vreadwire_d;
      fetch_valid_q <= fetch_valid_d;
      act_pipe_q    <= act_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      ls_pipe_q     <= ls_pipe_d;
      fs_pipe_q     <= fs_pipe_d;
      rgb_q         <= rgb_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hreadwire      = hreadwire_q;
  assign vreadwire      = vreadwire_q;
  assign fetch_valid    = fetch_valid_q;
  assign r              = rgb_q[COLOR_BITS-1:0];
  assign g              = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
  assign b              = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
  assign h_sync         = hs_pipe_q[PIPE-1];
  assign v_sync         = vs_pipe_q[PIPE-1];
  assign drawing_pixels = act_pipe_q[PIPE-1];
  assign line_start     = ls_pipe_q[PIPE-1];
  assign frame_start    = fs_pipe_q[PIPE-1];
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_vga_scaled_timing.sv
// Bench for vga_scaled_timing: a default 640x480 instance and a tiny scaled/inverted-sync instance
// checked every clock against a division-based raster model through an expected-output queue.
module tb_vga_scaled_timing;

  typedef struct packed {
    logic [3:0] r, g, b;
    logic hs, vs, dp, ls, fs;
  } exp_t;

  typedef struct packed {
    logic       fv;
    logic [9:0] h, v;
  } coord_t;

  typedef struct {
    int ha, hfp, hsw, va, vfp, vsw, ht, vt, s, pipe;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    bit rst;
    bit en;
    int n;
    int fca;
    int fcb;
  } phase_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  always #20 clk = ~clk;

  logic [11:0] pix_a, pix_b;
  logic [9:0]  hr_a, vr_a, hr_b, vr_b;
  logic        fv_a, fv_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, dp_a, ls_a, fs_a;
  logic        hs_b, vs_b, dp_b, ls_b, fs_b;
  logic [7:0]  fc_a, fc_b;

  vga_scaled_timing dut_a (
    .clk_25_175(clk), .reset(reset), .enable(enable), .pixstream(pix_a),
    .hreadwire(hr_a), .vreadwire(vr_a), .fetch_valid(fv_a),
    .r(r_a), .g(g_a), .b(b_a), .h_sync(hs_a), .v_sync(vs_a),
    .drawing_pixels(dp_a), .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_scaled_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SCALE(2), .COLOR_BITS(4), .FETCH_LATENCY(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_b (
    .clk_25_175(clk), .reset(reset), .enable(enable), .pixstream(pix_b),
    .hreadwire(hr_b), .vreadwire(vr_b), .fetch_valid(fv_b),
    .r(r_b), .g(g_b), .b(b_b), .h_sync(hs_b), .v_sync(vs_b),
    .drawing_pixels(dp_b), .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  // Frame source model: returns the requested coordinate's colour FETCH_LATENCY clocks later,
  // and junk for non-visible requests so blanking has to do real work.
  logic [11:0] cyc = '0;
  logic [20:0] dl_a = '0;
  logic [20:0] dl_b0 = '0, dl_b1 = '0, dl_b2 = '0;
  always @(posedge clk) begin
    cyc   <= cyc + 12'd1;
    dl_a  <= {fv_a, hr_a, vr_a};
    dl_b0 <= {fv_b, hr_b, vr_b};
    dl_b1 <= dl_b0;
    dl_b2 <= dl_b1;
  end

  function automatic logic [11:0] pix_of(input logic [20:0] d, input logic [11:0] junk);
    return d[20] ? {d[3:0], d[13:10], d[17:14]} : junk;
  endfunction

  assign pix_a = pix_of(dl_a, 12'hA5C ^ cyc);
  assign pix_b = pix_of(dl_b2, 12'h3C7 ^ cyc);

  int total = 0;
  int bad = 0;

  cfg_t   cfg [2];
  int     mh [2];
  int     mv [2];
  bit     run [2];
  coord_t ec [2];
  logic [7:0] efc [2];
  exp_t   q_a [$];
  exp_t   q_b [$];

  phase_t ph [6] = '{
    '{1'b1, 1'b1, 3,   0, 0},
    '{1'b0, 1'b1, 700, 1, 3},
    '{1'b0, 1'b0, 10,  1, 3},
    '{1'b0, 1'b1, 400, 2, 5},
    '{1'b1, 1'b1, 3,   0, 0},
    '{1'b0, 1'b1, 10,  1, 1}
  };

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  function automatic exp_t f_pins(input cfg_t c, input int h, input int v, input bit rn);
    exp_t e;
    bit act;
    logic [9:0] lh, lv;
    act  = rn && (h < c.ha) && (v < c.va);
    lh   = 10'(h / c.s);
    lv   = 10'(v / c.s);
    e.r  = act ? lh[7:4] : 4'd0;
    e.g  = act ? lh[3:0] : 4'd0;
    e.b  = act ? lv[3:0] : 4'd0;
    e.hs = (rn && h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : !c.hpol;
    e.vs = (rn && v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : !c.vpol;
    e.dp = act;
    e.ls = rn && (h == 0) && (v < c.va);
    e.fs = rn && (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic coord_t f_coord(input cfg_t c, input int h, input int v, input bit rn);
    coord_t k;
    k = '0;
    if (rn && h < c.ha && v < c.va) begin
      k.fv = 1'b1;
      k.h  = 10'(h / c.s);
      k.v  = 10'(v / c.s);
    end
    return k;
  endfunction

  task automatic push(input int i, input exp_t e);
    if (i == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  function automatic exp_t pop(input int i);
    exp_t e;
    e = '0;
    if (i == 0 && q_a.size() > 0) e = q_a.pop_front();
    if (i == 1 && q_b.size() > 0) e = q_b.pop_front();
    return e;
  endfunction

  // Pipeline starts out holding PIPE idle pixels.
  task automatic model_reset(input int i);
    if (i == 0) q_a.delete();
    else q_b.delete();
    for (int k = 0; k < cfg[i].pipe; k++) push(i, f_pins(cfg[i], 0, 0, 1'b0));
    mh[i] = 0; mv[i] = 0; run[i] = 1'b0; ec[i] = '0; efc[i] = '0;
  endtask

  task automatic model_step(input int i);
    ec[i] = f_coord(cfg[i], mh[i], mv[i], run[i]);
    if (reset) begin
      mh[i] = 0; mv[i] = 0; run[i] = 1'b0;
    end else begin
      if (!enable) begin
        mh[i] = 0; mv[i] = 0;
      end else if (run[i]) begin
        mh[i]++;
        if (mh[i] == cfg[i].ht) begin
          mh[i] = 0;
          mv[i]++;
          if (mv[i] == cfg[i].vt) mv[i] = 0;
        end
      end
      run[i] = enable;
    end
    push(i, f_pins(cfg[i], mh[i], mv[i], run[i]));
  endtask

  function automatic exp_t pins(input int i);
    return (i == 0) ? {r_a, g_a, b_a, hs_a, vs_a, dp_a, ls_a, fs_a}
                    : {r_b, g_b, b_b, hs_b, vs_b, dp_b, ls_b, fs_b};
  endfunction

  function automatic coord_t coords(input int i);
    return (i == 0) ? {fv_a, hr_a, vr_a} : {fv_b, hr_b, vr_b};
  endfunction

  task automatic check(input int i);
    exp_t e;
    e = pop(i);
    if (e.fs) efc[i] = efc[i] + 8'd1;
    chk(i == 0 ? "pins_a" : "pins_b", 32'(pins(i)), 32'(e));
    chk(i == 0 ? "coord_a" : "coord_b", 32'(coords(i)), 32'(ec[i]));
    chk(i == 0 ? "fcount_a" : "fcount_b", 32'(i == 0 ? fc_a : fc_b), 32'(efc[i]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check(0);
    check(1);
  endtask

  int hs_cnt, vs_cnt, dp_cnt, fv_cnt, ls_cnt, hmax, vmax;
  bit found;

  initial begin
    cfg[0] = '{640, 16, 96, 480, 10, 2, 800, 525, 1, 3, 1'b0, 1'b0};
    cfg[1] = '{16, 2, 3, 8, 1, 2, 24, 13, 2, 5, 1'b1, 1'b1};
    model_reset(0);
    model_reset(1);

    for (int p = 0; p < 6; p++) begin
      if (ph[p].rst && !reset) begin
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
          chk(i == 0 ? "async_pins_a" : "async_pins_b", 32'(pins(i)), 32'(f_pins(cfg[i], 0, 0, 1'b0)));
          chk(i == 0 ? "async_coord_a" : "async_coord_b", 32'(coords(i)), 32'd0);
          chk(i == 0 ? "async_fc_a" : "async_fc_b", 32'(i == 0 ? fc_a : fc_b), 32'd0);
          model_reset(i);
        end
      end
      if (!ph[p].rst) reset = 1'b0;
      enable = ph[p].en;
      repeat (ph[p].n) cycle();
      chk($sformatf("phase%0d_fc_a", p), 32'(fc_a), 32'(ph[p].fca));
      chk($sformatf("phase%0d_fc_b", p), 32'(fc_b), 32'(ph[p].fcb));
    end

    // One full 800-clock line of the default instance, starting at a line_start.
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      cycle();
      found = ls_a;
    end
    chk("ls_a_seen", 32'(found), 32'd1);
    if (found) begin
      hs_cnt = 0; dp_cnt = 0; fv_cnt = 0; ls_cnt = 0; hmax = 0;
      for (int k = 0; k < 800; k++) begin
        if (k > 0) cycle();
        hs_cnt += int'(!hs_a);
        dp_cnt += int'(dp_a);
        fv_cnt += int'(fv_a);
        ls_cnt += int'(ls_a);
        if (int'(hr_a) > hmax) hmax = int'(hr_a);
      end
      cycle();
      chk("a_hsync_low", 32'(hs_cnt), 32'd96);
      chk("a_drawing", 32'(dp_cnt), 32'd640);
      chk("a_fetch_valid", 32'(fv_cnt), 32'd640);
      chk("a_line_starts", 32'(ls_cnt), 32'd1);
      chk("a_hread_max", 32'(hmax), 32'd639);
      chk("a_line_period", 32'(ls_a), 32'd1);
    end

    // One full 312-clock frame of the scaled instance, starting at a frame_start.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      cycle();
      found = fs_b;
    end
    chk("fs_b_seen", 32'(found), 32'd1);
    if (found) begin
      hs_cnt = 0; vs_cnt = 0; dp_cnt = 0; fv_cnt = 0; ls_cnt = 0; hmax = 0; vmax = 0;
      for (int k = 0; k < 312; k++) begin
        if (k > 0) cycle();
        hs_cnt += int'(hs_b);
        vs_cnt += int'(vs_b);
        dp_cnt += int'(dp_b);
        fv_cnt += int'(fv_b);
        ls_cnt += int'(ls_b);
        if (int'(hr_b) > hmax) hmax = int'(hr_b);
        if (int'(vr_b) > vmax) vmax = int'(vr_b);
      end
      cycle();
      chk("b_hsync_high", 32'(hs_cnt), 32'd39);
      chk("b_vsync_high", 32'(vs_cnt), 32'd48);
      chk("b_drawing", 32'(dp_cnt), 32'd128);
      chk("b_fetch_valid", 32'(fv_cnt), 32'd128);
      chk("b_line_starts", 32'(ls_cnt), 32'd8);
      chk("b_hread_max", 32'(hmax), 32'd7);
      chk("b_vread_max", 32'(vmax), 32'd3);
      chk("b_frame_period", 32'(fs_b), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_scaled_timing.md
Name: vga_scaled_timing

Overview:
Parametrised VGA timing and pixel-pipeline core, the successor to the fixed 640x480 VGA core. It generates native-resolution raster counters, issues logical (down-scaled) pixel coordinates to the frame source, and absorbs a configurable fetch latency. It also delay-matches sync and blanking to the returned colour data and emits frame/line markers. It sits between the game renderer (pixel source) and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SCALE, 1, pixel replication factor (1, 2, 4 or 8); must divide H_ACTIVE and V_ACTIVE
COLOR_BITS, 4, bits per colour channel
FETCH_LATENCY, 1, clocks from hreadwire/vreadwire valid to matching pixstream valid (0..7)
HSYNC_POL, 0, active level of h_sync
VSYNC_POL, 0, active level of v_sync

Ports:
clk_25_175  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
enable  in  1  synchronous run enable
pixstream  in  3*COLOR_BITS  colour for the requested coordinate, {b,g,r}, r in LSBs
hreadwire  out  10  logical x coordinate requested (0..H_ACTIVE/SCALE-1)
vreadwire  out  10  logical y coordinate requested (0..V_ACTIVE/SCALE-1)
fetch_valid  out  1  hreadwire/vreadwire address a visible pixel
r, g, b  out  COLOR_BITS each  colour outputs, forced to 0 when blanked
h_sync  out  1  horizontal sync, level per HSYNC_POL
v_sync  out  1  vertical sync, level per VSYNC_POL
drawing_pixels  out  1  output pixel is visible
line_start  out  1  one-clock pulse with the first visible pixel of each line
frame_start  out  1  one-clock pulse with visible pixel (0,0)
frame_count  out  8  completed-frame counter, increments at frame_start, wraps 255->0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- hcnt counts 0..H_TOTAL-1 and wraps to 0. vcnt increments on hcnt wrap and counts 0..V_TOTAL-1. There is no off-by-one extra clock: line period is exactly H_TOTAL.
- Active area: hcnt<H_ACTIVE and vcnt<V_ACTIVE. Sync is active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and likewise for vcnt.
- Scaling uses sub-counters hsub/vsub (0..SCALE-1). No dividers.
  - hreadwire advances when hsub==SCALE-1 inside the active area and returns to 0 at line start.
  - vreadwire advances when vsub==SCALE-1 at the end of an active line and returns to 0 at frame start.
- Pipeline stage 0: counters. Stage 1: registered hreadwire, vreadwire, fetch_valid. While fetch_valid=0, the coordinates hold 0.
- pixstream is sampled FETCH_LATENCY clocks after stage 1, and r/g/b are registered one clock later. Total PIPE = FETCH_LATENCY+2 clocks from counter to pins.
- h_sync, v_sync, drawing_pixels, line_start and frame_start pass through a PIPE-deep shift register so they align exactly with r/g/b.
- r/g/b = sampled pixstream AND'ed with the delayed active flag.
- Reset (asynchronous, immediate, no clock needed):
  - counters, sub-counters, coordinates, fetch_valid, r/g/b, frame_count and all shift-register stages go to 0/inactive;
  - h_sync=!HSYNC_POL, v_sync=!VSYNC_POL, drawing_pixels=0, pulses=0.
  - After reset deasserts, hcnt=vcnt=0 on the first edge and frame_start fires PIPE clocks later.
- enable=0:
  - counters and sub-counters synchronously clear to 0 and the pipeline shifts in inactive values;
  - after PIPE clocks the outputs are blanked with syncs inactive.
  - On enable 0->1, the raster restarts at (0,0).
- Reset asserted mid-frame overrides enable and all pipeline contents, and no partial pulses are emitted.
- frame_count increments in the same clock that frame_start is high.

Test Plan:
- Defaults, enable=1, 2 frames -> h_sync low exactly 96 clocks per 800-clock line; v_sync low exactly 2 lines (1600 clocks); frame period 420000 clocks; frame_count 0->2.
- SCALE=2 -> per line hreadwire reads 0,0,1,1,...,319,319; vreadwire steps every 2 lines, max 239; fetch_valid high 640 clocks per active line.
- FETCH_LATENCY=3, bench model returns pixstream={v[3:0],h[3:0],h[7:4]} after 3 clocks -> every visible r/g/b matches its coordinate; first visible pixel 5 clocks after hcnt=0; r/g/b=0 when blanked.
- HSYNC_POL=1, VSYNC_POL=1 -> syncs high only in pulse windows; during and after reset they are low.
- Async reset at hcnt=300, vcnt=100 for 3 clocks -> outputs blank and syncs go inactive before the next edge; after release, frame_start fires PIPE clocks after the first edge and frame_count=1.
- enable dropped mid-line for 10 clocks -> blanking PIPE clocks later; on re-enable, raster restarts at (0,0) and line_start/frame_start fire together.
